// File: rtl/ssio_ddr_tx_ctrl_pkg.sv
// Shared definitions for the DDR link transmit sequencer: state encodings,
// control-lane codes and the fixed training/error data patterns.
package ssio_ddr_tx_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_TRAIN = 3'd0,
    ST_IDLE  = 3'd1,
    ST_DATA  = 3'd2,
    ST_DROP  = 3'd3,
    ST_GAP   = 3'd4
  } tx_state_e;

  // Control lane codes as {rising, falling}
  localparam logic [1:0] CTL_DATA = 2'b11;
  localparam logic [1:0] CTL_ERR  = 2'b10;
  localparam logic [1:0] CTL_IDLE = 2'b00;

  // Bit replicated across the lane for training and error markers
  localparam logic TRAIN_D1_BIT = 1'b1;
  localparam logic TRAIN_D2_BIT = 1'b0;
  localparam logic ERR_D_BIT    = 1'b1;

  localparam int UNDERRUN_W = 16;

  function automatic int cnt_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/ssio_ddr_tx_ctrl.sv
// Transmit sequencer: splits stream beats into rising/falling DDR halves,
// frames them on the control lane and runs training, gap and underrun recovery.
module ssio_ddr_tx_ctrl
  import ssio_ddr_tx_ctrl_pkg::*;
#(
  parameter int               WIDTH        = 4,
  parameter int               TRAIN_CYCLES = 16,
  parameter int               IFG_CYCLES   = 12,
  parameter logic [WIDTH-1:0] IDLE_D       = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2*WIDTH-1:0]    s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic                  train_req,
  output logic [WIDTH-1:0]      output_d1,
  output logic [WIDTH-1:0]      output_d2,
  output logic                  output_ctl_d1,
  output logic                  output_ctl_d2,
  output logic                  link_ready,
  output logic [UNDERRUN_W-1:0] underrun_count
);

  localparam int             CNT_W      = cnt_width(TRAIN_CYCLES, IFG_CYCLES);
  localparam logic [CNT_W-1:0] TRAIN_LOAD = CNT_W'(TRAIN_CYCLES);
  localparam logic [CNT_W-1:0] IFG_LOAD   = CNT_W'(IFG_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef struct packed {
    tx_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic             pending;
  } ctrl_t;

  ctrl_t                 ctrl_q, ctrl_d;
  logic [WIDTH-1:0]      d1_q, d1_d;
  logic [WIDTH-1:0]      d2_q, d2_d;
  logic [1:0]            ctl_q, ctl_d;
  logic [UNDERRUN_W-1:0] underrun_q, underrun_d;
  logic                  beat_acc;

  // Stream handshake: a beat transfers on a rising clk edge where tvalid and
  // tready are both high; tready is a function of registered state only, and
  // tvalid must not depend on tready.
  assign s_axis_tready = ((ctrl_q.state == ST_IDLE) && !ctrl_q.pending) ||
                         (ctrl_q.state == ST_DATA) || (ctrl_q.state == ST_DROP);
  assign beat_acc      = s_axis_tvalid && s_axis_tready;
  assign link_ready    = (ctrl_q.state != ST_TRAIN);

  assign output_d1      = d1_q;
  assign output_d2      = d2_q;
  assign output_ctl_d1  = ctl_q[1];
  assign output_ctl_d2  = ctl_q[0];
  assign underrun_count = underrun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q     <= '{state: ST_TRAIN, cnt: TRAIN_LOAD, pending: 1'b0};
      d1_q       <= '0;
      d2_q       <= '0;
      ctl_q      <= CTL_IDLE;
      underrun_q <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      d1_q       <= d1_d;
      d2_q       <= d2_d;
      ctl_q      <= ctl_d;
      underrun_q <= underrun_d;
    end
  end

  always_comb begin
    ctrl_d = ctrl_q;
    if (train_req && (ctrl_q.state != ST_TRAIN)) ctrl_d.pending = 1'b1;
    case (ctrl_q.state)
      ST_TRAIN: begin
        if (ctrl_q.cnt == CNT_ONE) ctrl_d.state = ST_IDLE;
        else                       ctrl_d.cnt   = ctrl_q.cnt - CNT_ONE;
      end
      ST_IDLE: begin
        if (ctrl_q.pending) begin
          ctrl_d.state   = ST_TRAIN;
          ctrl_d.cnt     = TRAIN_LOAD;
          ctrl_d.pending = 1'b0;
        end else if (beat_acc) begin
          if (s_axis_tlast) begin
            ctrl_d.state = ST_GAP;
            ctrl_d.cnt   = IFG_LOAD;
          end else begin
            ctrl_d.state = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (!s_axis_tvalid) begin
          ctrl_d.state = ST_DROP;
        end else if (s_axis_tlast) begin
          ctrl_d.state = ST_GAP;
          ctrl_d.cnt   = IFG_LOAD;
        end
      end
      ST_DROP: begin
        if (beat_acc && s_axis_tlast) begin
          ctrl_d.state = ST_GAP;
          ctrl_d.cnt   = IFG_LOAD;
        end
      end
      ST_GAP: begin
        if (ctrl_q.cnt == CNT_ONE) begin
          if (ctrl_q.pending) begin
            ctrl_d.state   = ST_TRAIN;
            ctrl_d.cnt     = TRAIN_LOAD;
            ctrl_d.pending = 1'b0;
          end else begin
            ctrl_d.state = ST_IDLE;
          end
        end else begin
          ctrl_d.cnt = ctrl_q.cnt - CNT_ONE;
        end
      end
      default: begin
        ctrl_d.state   = ST_TRAIN;
        ctrl_d.cnt     = TRAIN_LOAD;
        ctrl_d.pending = 1'b0;
      end
    endcase
  end

  always_comb begin
    d1_d       = IDLE_D;
    d2_d       = IDLE_D;
    ctl_d      = CTL_IDLE;
    underrun_d = underrun_q;
    case (ctrl_q.state)
      ST_TRAIN: begin
        d1_d = {WIDTH{TRAIN_D1_BIT}};
        d2_d = {WIDTH{TRAIN_D2_BIT}};
      end
      ST_IDLE: begin
        if (beat_acc) begin
          d1_d  = s_axis_tdata[WIDTH-1:0];
          d2_d  = s_axis_tdata[2*WIDTH-1:WIDTH];
          ctl_d = CTL_DATA;
        end
      end
      ST_DATA: begin
        if (s_axis_tvalid) begin
          d1_d  = s_axis_tdata[WIDTH-1:0];
          d2_d  = s_axis_tdata[2*WIDTH-1:WIDTH];
          ctl_d = CTL_DATA;
        end else begin
          // Mid-frame starvation: one error marker, then discard to tlast
          d1_d  = {WIDTH{ERR_D_BIT}};
          d2_d  = {WIDTH{ERR_D_BIT}};
          ctl_d = CTL_ERR;
          if (underrun_q != {UNDERRUN_W{1'b1}}) underrun_d = underrun_q + 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

endmodule
